// File: rtl/lstm_buf_pkg.sv
// Shared constants and helpers for the LSTM row buffers.
// Sizes address pointers and the full-bank count output.
package lstm_buf_pkg;

    localparam int ROWS_AVAIL_W = 2;

    // Pointer width needed to address 'value' entries.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lstm_pingpong_row_buffer_if.sv
// Producer/consumer handshake bundle of the ping-pong row buffer.
// The buffer uses the slave modport; loaders and the MAC array use the master modport.
interface lstm_pingpong_row_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 1
);
    logic                         wr_valid;
    logic                         wr_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] wr_data;
    logic                         rd_valid;
    logic                         rd_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] rd_data;
    logic                         rd_last;
    logic                         rd_replay;

    modport slave (
        input  wr_valid, wr_data, rd_ready, rd_replay,
        output wr_ready, rd_valid, rd_data, rd_last
    );

    modport master (
        output wr_valid, wr_data, rd_ready, rd_replay,
        input  wr_ready, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/lstm_row_bank.sv
// One row bank: synchronous write port, asynchronous read port.
// Deliberately has no reset so the array can map onto distributed/block RAM.
module lstm_row_bank #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/lstm_pingpong_row_buffer.sv
// Double-banked row buffer between the h/x loaders and the gate MAC array.
// Optional feature macro: LSTM_ROW_REPLAY_EN (rd_replay on the last beat keeps the row for another pass).
module lstm_pingpong_row_buffer
    import lstm_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 1,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    lstm_pingpong_row_buffer_if.slave bus,
    output logic                    row_done,
    output logic [ROWS_AVAIL_W-1:0] rows_avail,
    output logic [clog2(DEPTH):0]   write_count
);
    localparam int ADDR_WIDTH = clog2(DEPTH);
    localparam int WORD_W     = NUM_CH * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [1:0]            full;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  replay_take;
    logic                  release_bank;
    logic [WORD_W-1:0]     bank_rdata [2];

`ifdef LSTM_ROW_REPLAY_EN
    assign replay_take = bus.rd_replay;
`else
    logic unused_replay;
    assign unused_replay = bus.rd_replay;
    assign replay_take   = 1'b0;
`endif

    assign bus.wr_ready = !full[wr_bank] && !clear;
    assign wr_fire      = bus.wr_valid && bus.wr_ready;
    assign bus.rd_valid = full[rd_bank];
    assign rd_fire      = full[rd_bank] && bus.rd_ready && !clear;
    assign release_bank = rd_fire && (rd_ptr == LAST_ADDR) && !replay_take;
    assign bus.rd_last  = full[rd_bank] && (rd_ptr == LAST_ADDR);
    // Masking keeps never-written (X) memory off the bus while nothing is valid.
    assign bus.rd_data  = full[rd_bank] ? bank_rdata[rd_bank] : '0;

    assign rows_avail  = ROWS_AVAIL_W'(full[0]) + ROWS_AVAIL_W'(full[1]);
    assign write_count = {1'b0, wr_ptr};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        lstm_row_bank #(
            .WIDTH     (WORD_W),
            .DEPTH     (DEPTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_bank (
            .clk  (clk),
            .we   (wr_fire && (wr_bank == 1'(b))),
            .waddr(wr_ptr),
            .wdata(bus.wr_data),
            .raddr(rd_ptr),
            .rdata(bank_rdata[b])
        );
    end

    // Write and read sides always touch different banks, so their full-flag updates never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            row_done <= 1'b0;
        end else if (clear) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            row_done <= 1'b0;
        end else begin
            row_done <= release_bank;
            if (wr_fire) begin
                if (wr_ptr == LAST_ADDR) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_ptr        <= '0;
                end else begin
                    wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                end
            end
            if (rd_fire) begin
                if (rd_ptr == LAST_ADDR) begin
                    rd_ptr <= '0;
                    if (!replay_take) begin
                        full[rd_bank] <= 1'b0;
                        rd_bank       <= ~rd_bank;
                    end
                end else begin
                    rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_lstm_pingpong_row_buffer.sv
// Directed self-checking bench for lstm_pingpong_row_buffer (DEPTH=4, NUM_CH=2).
// Replay expectations follow LSTM_ROW_REPLAY_EN.
module tb_lstm_pingpong_row_buffer;
    localparam int DW    = 32;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       row_done;
    logic [1:0] rows_avail;
    logic [2:0] write_count;

    int compared   = 0;
    int mismatched = 0;

    lstm_pingpong_row_buffer_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

    lstm_pingpong_row_buffer #(
        .DATA_WIDTH(DW),
        .NUM_CH    (NCH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .bus        (bus),
        .row_done   (row_done),
        .rows_avail (rows_avail),
        .write_count(write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane l of word k carries k + 100*l so lane ordering is visible.
    function automatic logic [NCH*DW-1:0] mk_word(input int k);
        logic [NCH*DW-1:0] w;
        for (int l = 0; l < NCH; l++) w[l*DW +: DW] = DW'(k + 100 * l);
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int k);
        bus.wr_valid = 1'b1;
        bus.wr_data  = mk_word(k);
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;
        bus.rd_replay = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        compared++;
        if ({bus.wr_ready, bus.rd_valid, bus.rd_last, row_done, rows_avail, write_count} !== 9'b1_0_0_0_00_000) begin
            mismatched++;
            $display("[TB] FAIL reset_flags got %b expected %b",
                     {bus.wr_ready, bus.rd_valid, bus.rd_last, row_done, rows_avail, write_count}, 9'b1_0_0_0_00_000);
        end
        compared++;
        if (bus.rd_data !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_rd_data got %h expected 0", bus.rd_data);
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        bus.rd_ready = 1'b0;
        for (int k = 1; k <= 8; k++) write_word(k);
        compared++;
        if (rows_avail !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL b2b_rows_avail got %0d expected 2", rows_avail);
        end
        compared++;
        if (bus.wr_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_wr_ready_full got %b expected 0", bus.wr_ready);
        end
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (bus.rd_data !== mk_word(i + 1)) begin
                mismatched++;
                $display("[TB] FAIL b2b_data beat %0d got %h expected %h", i + 1, bus.rd_data, mk_word(i + 1));
            end
            compared++;
            if (bus.rd_last !== ((i == 3) || (i == 7))) begin
                mismatched++;
                $display("[TB] FAIL b2b_rd_last beat %0d got %b expected %b", i + 1, bus.rd_last, (i == 3) || (i == 7));
            end
            step();
            if (row_done) done_cnt++;
            if (i == 2) begin
                compared++;
                if (bus.wr_ready !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_wr_ready_before_release got %b expected 0", bus.wr_ready);
                end
            end
            if (i == 3) begin
                compared++;
                if (bus.wr_ready !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_wr_ready_after_release got %b expected 1", bus.wr_ready);
                end
            end
        end
        bus.rd_ready = 1'b0;
        step();
        compared++;
        if (done_cnt !== 2) begin
            mismatched++;
            $display("[TB] FAIL b2b_row_done_count got %0d expected 2", done_cnt);
        end
        compared++;
        if ({row_done, bus.rd_valid, rows_avail} !== 4'b0_0_00) begin
            mismatched++;
            $display("[TB] FAIL b2b_drained got %b expected 0000", {row_done, bus.rd_valid, rows_avail});
        end
    endtask

    task automatic test_concurrent();
        int wr_idx = 0;
        int rd_idx = 0;
        bus.rd_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && rd_idx < 12; cyc++) begin
            bus.wr_valid = (wr_idx < 12);
            bus.wr_data  = mk_word(wr_idx + 1);
            #1;
            if (bus.rd_valid) begin
                compared++;
                if (bus.rd_data !== mk_word(rd_idx + 1)) begin
                    mismatched++;
                    $display("[TB] FAIL stream_data idx %0d got %h expected %h", rd_idx + 1, bus.rd_data, mk_word(rd_idx + 1));
                end
                rd_idx++;
            end
            if (wr_idx >= 4 && wr_idx < 12) begin
                compared++;
                if (bus.wr_ready !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL stream_wr_ready word %0d got %b expected 1", wr_idx + 1, bus.wr_ready);
                end
            end
            if (bus.wr_valid && bus.wr_ready) wr_idx++;
            step();
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        compared++;
        if (rd_idx !== 12) begin
            mismatched++;
            $display("[TB] FAIL stream_count got %0d words expected 12", rd_idx);
        end
        compared++;
        if (rows_avail !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL stream_rows_avail got %0d expected 0", rows_avail);
        end
    endtask

    task automatic test_backpressure();
        int pat[4] = '{1, 0, 0, 1};
        int rd_idx = 0;
        for (int k = 21; k <= 24; k++) write_word(k);
        for (int cyc = 0; cyc < 16 && rd_idx < 4; cyc++) begin
            bus.rd_ready = (pat[cyc % 4] == 1);
            #1;
            compared++;
            if (bus.rd_data !== mk_word(21 + rd_idx)) begin
                mismatched++;
                $display("[TB] FAIL bp_data cycle %0d got %h expected %h", cyc, bus.rd_data, mk_word(21 + rd_idx));
            end
            compared++;
            if (bus.rd_last !== (rd_idx == 3)) begin
                mismatched++;
                $display("[TB] FAIL bp_rd_last cycle %0d got %b expected %b", cyc, bus.rd_last, rd_idx == 3);
            end
            if (bus.rd_ready) rd_idx++;
            step();
        end
        bus.rd_ready = 1'b0;
        compared++;
        if (rd_idx !== 4 || bus.rd_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bp_end got beats=%0d rd_valid=%b expected beats=4 rd_valid=0", rd_idx, bus.rd_valid);
        end
    endtask

    task automatic test_replay();
        int beats     = 0;
        int done_cnt  = 0;
        int done_beat = -1;
`ifdef LSTM_ROW_REPLAY_EN
        int exp_beats = 16;
`else
        int exp_beats = 4;
`endif
        for (int k = 1; k <= 4; k++) write_word(10 * k);
        bus.rd_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && bus.rd_valid; cyc++) begin
            bus.rd_replay = ((beats / 4) < 3);
            compared++;
            if (bus.rd_data !== mk_word(10 * ((beats % 4) + 1))) begin
                mismatched++;
                $display("[TB] FAIL replay_data beat %0d got %h expected %h", beats + 1, bus.rd_data, mk_word(10 * ((beats % 4) + 1)));
            end
            step();
            beats++;
            if (row_done) begin
                done_cnt++;
                done_beat = beats;
            end
        end
        bus.rd_ready  = 1'b0;
        bus.rd_replay = 1'b0;
        repeat (2) begin
            step();
            if (row_done) done_cnt++;
        end
        compared++;
        if (beats !== exp_beats) begin
            mismatched++;
            $display("[TB] FAIL replay_beats got %0d expected %0d", beats, exp_beats);
        end
        compared++;
        if (done_cnt !== 1 || done_beat !== exp_beats) begin
            mismatched++;
            $display("[TB] FAIL replay_row_done got count=%0d at beat %0d expected count=1 at beat %0d", done_cnt, done_beat, exp_beats);
        end
        compared++;
        if (bus.rd_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL replay_rd_valid_after got %b expected 0", bus.rd_valid);
        end
    endtask

    task automatic test_mid_row_flush(input bit use_clear);
        write_word(50);
        write_word(51);
        compared++;
        if (write_count !== 3'd2) begin
            mismatched++;
            $display("[TB] FAIL flush_partial_count got %0d expected 2", write_count);
        end
        if (use_clear) begin
            clear        = 1'b1;
            bus.wr_valid = 1'b1;
            bus.wr_data  = mk_word(99);
            #1;
            compared++;
            if (bus.wr_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL clear_wr_ready got %b expected 0", bus.wr_ready);
            end
            step();
            clear        = 1'b0;
            bus.wr_valid = 1'b0;
        end else begin
            rst_n = 1'b0;
            #1;
            step();
            rst_n = 1'b1;
        end
        compared++;
        if ({bus.rd_valid, rows_avail, write_count} !== 6'b0_00_000 || bus.rd_data !== '0) begin
            mismatched++;
            $display("[TB] FAIL flush_state clear=%0d got %b data %h expected 000000 data 0",
                     use_clear, {bus.rd_valid, rows_avail, write_count}, bus.rd_data);
        end
        for (int k = 7; k <= 10; k++) begin
            compared++;
            if (write_count !== 3'(k - 7)) begin
                mismatched++;
                $display("[TB] FAIL flush_write_count clear=%0d got %0d expected %0d", use_clear, write_count, k - 7);
            end
            write_word(k);
        end
        compared++;
        if (write_count !== 3'd0 || rows_avail !== 2'd1) begin
            mismatched++;
            $display("[TB] FAIL flush_row_full clear=%0d got count=%0d avail=%0d expected 0 and 1", use_clear, write_count, rows_avail);
        end
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (bus.rd_data !== mk_word(7 + i)) begin
                mismatched++;
                $display("[TB] FAIL flush_data clear=%0d beat %0d got %h expected %h", use_clear, i + 1, bus.rd_data, mk_word(7 + i));
            end
            step();
        end
        bus.rd_ready = 1'b0;
        compared++;
        if (bus.rd_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL flush_rd_valid_after clear=%0d got %b expected 0", use_clear, bus.rd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_concurrent();
        test_backpressure();
        test_replay();
        test_mid_row_flush(1'b0);
        test_mid_row_flush(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/lstm_pingpong_row_buffer.md
# lstm_pingpong_row_buffer

- Parametrised, double-banked successor to the LSTM single-row BRAM buffer.
- A producer fills one bank with a row of `DEPTH` words, each `NUM_CH` lanes wide, while the consumer drains the other bank.
- Both sides use valid/ready handshakes, and addresses are generated internally.
- It sits between the input/hidden-state loaders and the gate MAC array. Optionally, a row can be replayed so that one h/x vector feeds all four gate passes without reloading.

## Interface
- `DATA_WIDTH`, 32, bits per lane
- `NUM_CH`, 1, lanes per word; the data buses are `NUM_CH*DATA_WIDTH` wide, with lane 0 in the LSBs
- `DEPTH`, 4, words per row (≥2)
- `ADDR_WIDTH`, `$clog2(DEPTH)`, localparam, not overridable
- `clk` in 1: the single clock; every register is updated on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `clear` in 1: synchronous flush, with priority over all other activity
- `wr_valid` in 1: producer has a word
- `wr_ready` out 1: buffer accepts a word
- `wr_data` in `NUM_CH*DATA_WIDTH`: write word
- `rd_valid` out 1: a full row is available to read
- `rd_ready` in 1: consumer takes the current word
- `rd_data` out `NUM_CH*DATA_WIDTH`: read word
- `rd_last` out 1: current read word is the final word of the row
- `rd_replay` in 1: sampled with the final read beat; holds the row for another pass
- `row_done` out 1: one-cycle pulse when a bank is released
- `rows_avail` out 2: number of full banks (0 to 2)
- `write_count` out `ADDR_WIDTH+1`: words written into the current fill bank

## Operation
- **Banks:** two banks, each `DEPTH` × `NUM_CH*DATA_WIDTH`. Each bank has a `full` flag.
- **Pointers:** `wr_bank`, `wr_ptr`, `rd_bank`, `rd_ptr`.
- **Write accept:** a write is accepted when `wr_valid && wr_ready`, where `wr_ready = !full[wr_bank] && !clear`.
  - The word is stored at `bank[wr_bank][wr_ptr]` and `wr_ptr` is incremented.
  - On the write at `wr_ptr==DEPTH-1`: set `full[wr_bank]`, toggle `wr_bank`, set `wr_ptr` to 0.
- **Read outputs:**
  - `rd_valid = full[rd_bank]`.
  - `rd_data = bank[rd_bank][rd_ptr]` combinationally; it is all-zero whenever `rd_valid` is 0.
  - `rd_last = rd_valid && rd_ptr==DEPTH-1`.
- **Read accept:** a read beat occurs on `rd_valid && rd_ready` and increments `rd_ptr`.
  - On the last beat, `rd_ptr` goes to 0.
  - If no replay is taken: clear `full[rd_bank]`, toggle `rd_bank`, and pulse `row_done` in the next cycle.
- **Row order:** rows are read strictly in the order they were written.
- **`write_count`:** equals `wr_ptr`. Because `wr_ptr` wraps to 0 on the last write, `write_count` never reaches `DEPTH`.
- **`rows_avail`:** equals `full[0]+full[1]`.
- **`clear`:** zeroes all flags and pointers and suppresses any write or read in that cycle. Memory contents are untouched.
- **Reset:** memory is not reset, so it is BRAM-inferable. No X values reach `rd_data` because of the zero mask.

## Timing
- **Reset values:**
  - `wr_ready`=1
  - `rd_valid`=0, `rd_data`=0, `rd_last`=0
  - `row_done`=0
  - `rows_avail`=0
  - `write_count`=0
- **Write-to-read latency:** the last write is accepted in cycle N, and `rd_valid` is 1 in cycle N+1. The first word is readable in N+1.
- **Throughput:** one word per cycle on each side concurrently.
- **Simultaneous write and read on different banks:** both take effect.
- **Both banks full:** `wr_ready`=0 until the release edge. `wr_ready` returns to 1 in the cycle after the last read beat.
- **Release then refill:** a bank released by a read in cycle N can accept writes from cycle N+1. There is no bypass.
- **`row_done`:** registered and high for exactly one cycle.
- **Reset mid-row:** the partial row is discarded, with all state back to the reset values.
- **`clear` mid-row:** same result, but synchronous.

## Configuration
- Macro: `LSTM_ROW_REPLAY_EN`.
- **Defined:** if `rd_replay`=1 on the last read beat, the bank stays full and `rd_bank` is unchanged.
  - `rd_ptr` wraps to 0, `row_done` is not pulsed, and `rd_valid` stays 1.
  - Any number of replays is allowed.
- **Undefined:** the `rd_replay` port remains but is ignored, and every last beat releases the bank.

## Structure
- **Shared package `lstm_buf_pkg`:**
  - A `clog2` function or constant helper for `ADDR_WIDTH`.
  - The `ROWS_AVAIL_W=2` constant.
- **Sub-module `lstm_row_bank`:** a single bank with one synchronous write port, one asynchronous read port and no reset. It is instantiated twice.
- **Top level:** holds the pointers, the full flags, the handshake logic and the output masking.

## Test plan
- **Back-to-back rows:** DEPTH=4, NUM_CH=2. Write words 1..4 (row A), then 5..8 (row B) with `rd_ready`=0.
  - Expected: `rows_avail`=2 and `wr_ready`=0.
  - Then read 8 beats: data 1..8, `rd_last` on beats 4 and 8, `row_done` pulses twice.
- **Concurrent fill and drain:** stream 12 words in with `rd_ready`=1 throughout.
  - Expected: `rd_data` order 1..12, no lost or duplicated words, and `wr_ready` never drops after the first row.
- **Backpressure:** toggle `rd_ready` in the pattern 1,0,0,1 during a row.
  - Expected: `rd_data` holds while stalled, and `rd_ptr` advances only on handshake beats.
- **Replay** (`LSTM_ROW_REPLAY_EN` defined): fill the row 10,20,30,40, then read with `rd_replay`=1 for 3 passes and 0 on the 4th.
  - Expected: 16 beats read, and exactly one `row_done` after the 16th beat.
  - With the macro undefined, the same stimulus gives one `row_done` after beat 4, and `rd_valid`=0 afterwards.
- **Mid-row reset and clear:** write 2 of 4 words, assert `rst_n`=0 (or `clear`=1) for 1 cycle, then write 4 new words 7,8,9,10.
  - Expected: the read returns 7,8,9,10 only, and `write_count` sequence 0,1,2,3,0.
